// File: rtl/ti_sbox_pipe.sv
// ti_sbox_pipe -- pipelined 3-share threshold-implementation S-box layer.
//
// STAGES cascaded quadratic TI component layers act on NIBBLES nibbles per
// share. Layer k is the combinational logic that feeds stage register k.
// Stage 0 takes the input shares, and stage k>0 takes stage k-1. The last
// stage register drives out_s* directly, so the output passes through no
// further logic. A register between every layer isolates glitches. The
// stages form an elastic valid/ready pipeline.
//
// Share rotation per layer (non-complete): y1=F(x2,x3), y2=F(x3,x1), y3=F(x1,x2).
// Across the three shares F sums to the unshared nibble map Q:
//   q0 = x0 ^ x1&x2
//   q1 = x1 ^ x2&x3
//   q2 = x2 ^ x1 ^ x0&x3
//   q3 = ~(x3 ^ x0&x1)
//
// Optional feature: define TI_REFRESH_EN to re-mask the shares with rnd at
// every stage-k load (k>0). Without it, rnd is ignored.

module ti_sbox_pipe #(
    parameter int NIBBLES = 16,
    parameter int STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_s1,
    input  logic [4*NIBBLES-1:0]   in_s2,
    input  logic [4*NIBBLES-1:0]   in_s3,
    input  logic [8*NIBBLES-1:0]   rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_s1,
    output logic [4*NIBBLES-1:0]   out_s2,
    output logic [4*NIBBLES-1:0]   out_s3,
    output logic                   busy
);

    localparam int W = 4 * NIBBLES;

    // One share of the quadratic component. p is the first-listed share and
    // q is the second-listed share. Each product a&b is split as
    // pa&pb ^ pa&qb ^ qa&pb. Across the three rotations this sums to a&b.
    // Linear terms and the constant are taken from p only. Three copies of
    // the constant XOR back to one.
    function automatic logic [3:0] comp_f(input logic [3:0] p, input logic [3:0] q);
        logic [3:0] y;
        y[0] = p[0] ^ (p[1] & p[2]) ^ (p[1] & q[2]) ^ (q[1] & p[2]);
        y[1] = p[1] ^ (p[2] & p[3]) ^ (p[2] & q[3]) ^ (q[2] & p[3]);
        y[2] = p[2] ^ p[1] ^ (p[0] & p[3]) ^ (p[0] & q[3]) ^ (q[0] & p[3]);
        y[3] = ~(p[3] ^ (p[0] & p[1]) ^ (p[0] & q[1]) ^ (q[0] & p[1]));
        return y;
    endfunction

    // Applies the component to every nibble of one share word.
    function automatic logic [W-1:0] layer_f(input logic [W-1:0] p, input logic [W-1:0] q);
        logic [W-1:0] y;
        y = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            y[4*n +: 4] = comp_f(p[4*n +: 4], q[4*n +: 4]);
        end
        return y;
    endfunction

    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   adv_chain;
    logic [STAGES:0]   occ;

    logic [W-1:0] d1_reg [STAGES];
    logic [W-1:0] d2_reg [STAGES];
    logic [W-1:0] d3_reg [STAGES];

    // A virtual always-occupied stage beyond the last one turns the
    // last-stage rule (v & out_ready) into the same form as the others.
    assign occ = {1'b1, v_reg};

    // The advance chain runs from the output back toward the input.
    always_comb begin
        adv_chain = '0;
        adv_chain[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv_chain[k] = v_reg[k] & (!occ[k+1] | adv_chain[k+1]);
        end
    end

    assign adv       = adv_chain[STAGES-1:0];
    assign in_ready  = !flush && (!v_reg[0] || adv[0]);
    assign out_valid = v_reg[STAGES-1];
    assign busy      = |v_reg;
    assign out_s1    = d1_reg[STAGES-1];
    assign out_s2    = d2_reg[STAGES-1];
    assign out_s3    = d3_reg[STAGES-1];

    // Stage valids: flush clears all of them. A load sets the valid.
    // Advancing without a refill clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg <= '0;
        end else if (flush) begin
            v_reg <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_reg[k] <= 1'b1;
                end else if (adv[k]) begin
                    v_reg[k] <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [W-1:0] x1, x2, x3;
            logic [W-1:0] y1, y2, y3;
            logic [W-1:0] n1, n2, n3;

            if (gi == 0) begin : g_src_in
                assign x1 = in_s1;
                assign x2 = in_s2;
                assign x3 = in_s3;
                assign load[gi] = in_valid & in_ready;
            end else begin : g_src_prev
                assign x1 = d1_reg[gi-1];
                assign x2 = d2_reg[gi-1];
                assign x3 = d3_reg[gi-1];
                assign load[gi] = adv[gi-1] & !flush;
            end

            assign y1 = layer_f(x2, x3);
            assign y2 = layer_f(x3, x1);
            assign y3 = layer_f(x1, x2);

`ifdef TI_REFRESH_EN
            if (gi > 0) begin : g_refresh
                // The XOR of the three masks is zero, so the unshared value
                // is unchanged.
                assign n1 = y1 ^ rnd[W-1:0];
                assign n2 = y2 ^ rnd[2*W-1:W];
                assign n3 = y3 ^ rnd[W-1:0] ^ rnd[2*W-1:W];
            end else begin : g_no_refresh
                assign n1 = y1;
                assign n2 = y2;
                assign n3 = y3;
            end
`else
            assign n1 = y1;
            assign n2 = y2;
            assign n3 = y3;
`endif

            // Share registers change only on their own load, so idle shares
            // never toggle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d1_reg[gi] <= '0;
                    d2_reg[gi] <= '0;
                    d3_reg[gi] <= '0;
                end else if (load[gi]) begin
                    d1_reg[gi] <= n1;
                    d2_reg[gi] <= n2;
                    d3_reg[gi] <= n3;
                end
            end
        end
    endgenerate

`ifndef TI_REFRESH_EN
    logic rnd_unused;
    assign rnd_unused = ^rnd;
`endif

endmodule

// File: tb/tb_ti_sbox_pipe.sv
// tb_ti_sbox_pipe -- directed checks for ti_sbox_pipe (NIBBLES=16, STAGES=2).
// The golden model is an unshared nibble lookup of Q, applied STAGES times.
// The hand-derived constants in the vector table are the expected results.
// Honours TI_REFRESH_EN in the share-repeatability sequence.

module tb_ti_sbox_pipe;

    localparam int NIBBLES = 16;
    localparam int STAGES  = 2;
    localparam int W       = 4 * NIBBLES;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_s1 = '0;
    logic [W-1:0]   in_s2 = '0;
    logic [W-1:0]   in_s3 = '0;
    logic [2*W-1:0] rnd = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_s1;
    logic [W-1:0]   out_s2;
    logic [W-1:0]   out_s3;
    logic           busy;

    int checks = 0;
    int errors = 0;

    ti_sbox_pipe #(.NIBBLES(NIBBLES), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [W-1:0] s3;
        logic [W-1:0] exp_x;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Unshared reference: a nibble lookup of Q, applied STAGES times.
    function automatic logic [W-1:0] gold(input logic [W-1:0] x);
        logic [3:0] qt [16];
        logic [W-1:0] y;
        qt = '{4'h8, 4'h9, 4'hE, 4'h7, 4'hC, 4'hD, 4'hB, 4'h2,
               4'h0, 4'h5, 4'h6, 4'hB, 4'h6, 4'h3, 4'h1, 4'hC};
        y = x;
        for (int s = 0; s < STAGES; s++) begin
            for (int n = 0; n < NIBBLES; n++) begin
                y[4*n +: 4] = qt[y[4*n +: 4]];
            end
        end
        return y;
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom()};
    endfunction

    // Moves to the next falling edge, then refreshes the randomness input.
    task automatic next_cyc();
        @(negedge clk);
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Pushes one vector into an empty pipe and waits for its result. Checks
    // the latency and the unshared value, and returns the output shares.
    task automatic apply_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] req,
                                output logic [W-1:0] o1, output logic [W-1:0] o2,
                                output logic [W-1:0] o3);
        int lat;
        next_cyc();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_s1 = a;
        in_s2 = b;
        in_s3 = c;
        #1;
        check("single_in_ready", {63'd0, in_ready}, 64'd1);
        next_cyc();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            next_cyc();
            lat++;
        end
        check("single_latency", 64'(lat), 64'(STAGES));
        check("single_xor", out_s1 ^ out_s2 ^ out_s3, req);
        o1 = out_s1;
        o2 = out_s2;
        o3 = out_s3;
        $display("vec %0d latency %0d xor %h", id, lat, out_s1 ^ out_s2 ^ out_s3);
    endtask

    logic [W-1:0] exp_q [$];
    logic [W-1:0] a, b, c, o1, o2, o3, p1, p2, p3, h1, h2, h3;
    int pushed, got, first, last, accepts;
    bit held;

    initial begin
        tbl[0] = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h051263BE8DBBB796};
        tbl[1] = '{64'h0, 64'h0, 64'h0, 64'h0};
        tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h6666666666666666};
        tbl[3] = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h0, 64'h6666666666666666};
        tbl[4] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                   64'h051263BE8DBBB796};
        tbl[5] = '{64'hFEDCBA9876543210, 64'h0, 64'h0, 64'h697BBBD8EB362150};
        tbl[6] = '{64'h1111111111111111, 64'h2222222222222222, 64'h4444444444444444,
                   64'hEEEEEEEEEEEEEEEE};

        // Reset state
        repeat (2) next_cyc();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_s1", out_s1, 64'd0);
        check("rst_out_s2", out_s2, 64'd0);
        check("rst_out_s3", out_s3, 64'd0);
        rst_n = 1'b1;
        next_cyc();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Table vectors, each pushed into an empty pipe
        for (int i = 0; i < 7; i++) begin
            apply_single(i, tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].exp_x, o1, o2, o3);
        end

        // 32 back-to-back random vectors
        next_cyc();
        out_ready = 1'b1;
        pushed = 0; got = 0; first = -1; last = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 32 + STAGES + 10; cyc++) begin
            next_cyc();
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("b2b_result", out_s1 ^ out_s2 ^ out_s3, exp_q.pop_front());
                end else begin
                    check("b2b_extra_output", {63'd0, out_valid}, 64'd0);
                end
                $display("b2b out %0d cycle %0d xor %h", got, cyc, out_s1 ^ out_s2 ^ out_s3);
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (pushed < 32) begin
                a = rand_w(); b = rand_w(); c = rand_w();
                in_valid = 1'b1;
                in_s1 = a; in_s2 = b; in_s3 = c;
                #1;
                check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
                if (in_ready) exp_q.push_back(gold(a ^ b ^ c));
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("b2b_count", 64'(got), 64'd32);
        check("b2b_consecutive", 64'(last - first), 64'd31);

        // Output stall for 10 cycles while pushing
        exp_q.delete();
        out_ready = 1'b0;
        accepts = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            next_cyc();
            if (out_valid) begin
                if (!held) begin
                    h1 = out_s1; h2 = out_s2; h3 = out_s3;
                    held = 1'b1;
                end else begin
                    check("stall_s1_stable", out_s1, h1);
                    check("stall_s2_stable", out_s2, h2);
                    check("stall_s3_stable", out_s3, h3);
                end
            end
            a = rand_w(); b = rand_w(); c = rand_w();
            in_valid = 1'b1;
            in_s1 = a; in_s2 = b; in_s3 = c;
            #1;
            if (in_ready) begin
                accepts++;
                exp_q.push_back(gold(a ^ b ^ c));
            end
        end
        check("stall_accepts", 64'(accepts), 64'(STAGES));
        check("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
        next_cyc();
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < STAGES + 6; i++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("stall_drain_result", out_s1 ^ out_s2 ^ out_s3, exp_q.pop_front());
                end else begin
                    check("stall_extra_output", {63'd0, out_valid}, 64'd0);
                end
                $display("drain out %0d xor %h", got, out_s1 ^ out_s2 ^ out_s3);
                got++;
            end
            next_cyc();
        end
        check("stall_drain_count", 64'(got), 64'(STAGES));

        // Flush on a full pipe, with in_valid high
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            next_cyc();
            in_valid = 1'b1;
            in_s1 = rand_w(); in_s2 = rand_w(); in_s3 = rand_w();
        end
        next_cyc();
        check("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        in_s1 = rand_w();
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        next_cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        $display("flush done busy %0b out_valid %0b", busy, out_valid);
        apply_single(100, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].exp_x, o1, o2, o3);

        // Asynchronous reset pulse mid-stream, away from the clock edge
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            next_cyc();
            in_valid = 1'b1;
            in_s1 = rand_w(); in_s2 = rand_w(); in_s3 = rand_w();
        end
        next_cyc();
        in_valid = 1'b0;
        check("arst_pre_out_valid", {63'd0, out_valid}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_out_s1", out_s1, 64'd0);
        check("arst_out_s2", out_s2, 64'd0);
        check("arst_out_s3", out_s3, 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            check("arst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        $display("async reset done busy %0b", busy);

        // Share repeatability with fresh randomness every cycle
        apply_single(200, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].exp_x, p1, p2, p3);
        apply_single(201, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].exp_x, o1, o2, o3);
`ifdef TI_REFRESH_EN
        checks++;
        if (p1 == o1 && p2 == o2 && p3 == o3) begin
            errors++;
            $display("FAIL refresh_shares_differ actual=%h required=not %h", o1, p1);
        end
`else
        check("repeat_s1_run1", p1, 64'h0426264006242442);
        check("repeat_s2_run1", p2, 64'h013445FE8B9F93D4);
        check("repeat_s3_run1", p3, 64'h0);
        check("repeat_s1_run2", o1, 64'h0426264006242442);
        check("repeat_s2_run2", o2, 64'h013445FE8B9F93D4);
        check("repeat_s3_run2", o3, 64'h0);
`endif

        next_cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
